// File: rtl/niosii_ocimem_pkg.sv
// Shared types and jdo field positions for the OCI debug-RAM sequencer.
// Used by niosii_nios2_gen2_0_cpu_ocimem_seq and niosii_ocimem_timeout.
package niosii_ocimem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        READ      = 2'd0,
        READ_INC  = 2'd1,
        WRITE_INC = 2'd2
    } cmd_t;

    localparam int JDO_ADDR_LSB  = 10;
    localparam int JDO_WDATA_LSB = 3;
    localparam int JDO_RD_BIT    = 35;
    localparam int JDO_CLR_BIT   = 36;

endpackage

// File: rtl/niosii_ocimem_timeout.sv
// ACCESS-state cycle counter; flags expiry on the TIMEOUT-th cycle.
// Only instantiated when OCIMEM_TIMEOUT_EN is defined.
module niosii_ocimem_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    assign expired = run && (cnt == CW'(TIMEOUT - 1));

    // Count cycles spent in ACCESS; restart whenever the sequencer leaves it.
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            cnt <= '0;
        end else if (!expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/niosii_nios2_gen2_0_cpu_ocimem_seq.sv
// Debug-RAM access sequencer driven by JTAG ocimem strobes.
// Optional ACCESS timeout enabled by defining OCIMEM_TIMEOUT_EN.
module niosii_nios2_gen2_0_cpu_ocimem_seq
    import niosii_ocimem_pkg::*;
#(
    parameter int AW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [37:0]   jdo,
    input  logic          take_action_ocimem_a,
    input  logic          take_action_ocimem_b,
    input  logic          take_no_action_ocimem_a,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ack,
    input  logic          mem_err,
    input  logic [31:0]   mem_rdata,
    output logic [31:0]   MonDReg,
    output logic          monitor_ready,
    output logic          monitor_error
);

    state_t        state;
    state_t        next_state;
    cmd_t          cmd;
    logic [AW-1:0] addr;
    logic [AW-1:0] jdo_addr;
    logic [31:0]   jdo_wdata;
    logic          in_access;
    logic          take_a;
    logic          take_b;
    logic          take_n;
    logic          start;
    logic          overrun;
    logic          tmo_expired;
    logic          finish;
    logic          err_set;
    logic          err_clr;

    assign jdo_addr  = jdo[JDO_ADDR_LSB +: AW];
    assign jdo_wdata = jdo[JDO_WDATA_LSB +: 32];
    assign in_access = (state == ACCESS);

    // Ready is forced low while reset is asserted.
    assign monitor_ready = (state == IDLE) && !reset;

`ifdef OCIMEM_TIMEOUT_EN
    niosii_ocimem_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .run     (in_access),
        .expired (tmo_expired)
    );

    logic unused_bits;
    assign unused_bits = ^{jdo[37], jdo[2:0]};
`else
    assign tmo_expired = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{jdo[37], jdo[2:0], TIMEOUT[0]};
`endif

    // Strobe arbitration, error sources and next-state decode.
    always_comb begin
        take_b     = 1'b0;
        take_a     = 1'b0;
        take_n     = 1'b0;
        overrun    = 1'b0;
        next_state = state;
        if (state == IDLE) begin
            take_b = take_action_ocimem_b;
            take_a = take_action_ocimem_a && !take_action_ocimem_b;
            take_n = take_no_action_ocimem_a && !take_action_ocimem_a
                     && !take_action_ocimem_b;
        end else begin
            overrun = take_action_ocimem_a || take_action_ocimem_b
                      || take_no_action_ocimem_a;
        end
        start   = take_b || take_n || (take_a && jdo[JDO_RD_BIT]);
        finish  = in_access && (mem_ack || tmo_expired);
        err_set = overrun || (in_access && mem_ack && mem_err)
                  || (in_access && tmo_expired && !mem_ack);
        err_clr = take_a && jdo[JDO_CLR_BIT];
        unique case (state)
            IDLE:    if (start) next_state = ACCESS;
            ACCESS:  if (finish) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Command capture, memory-port registers and completion write-back.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd       <= READ;
            addr      <= '0;
            MonDReg   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_req <= (next_state == ACCESS);
            if (take_b) begin
                cmd       <= WRITE_INC;
                mem_we    <= 1'b1;
                mem_addr  <= addr;
                mem_wdata <= jdo_wdata;
            end else if (take_a) begin
                addr <= jdo_addr;
                if (jdo[JDO_RD_BIT]) begin
                    cmd      <= READ;
                    mem_we   <= 1'b0;
                    mem_addr <= jdo_addr;
                end
            end else if (take_n) begin
                cmd      <= READ_INC;
                mem_we   <= 1'b0;
                mem_addr <= addr;
            end
            if (in_access && mem_ack && !mem_err) begin
                if (cmd != WRITE_INC) MonDReg <= mem_rdata;
                if (cmd != READ) addr <= addr + 1'b1;
            end
            if (finish) mem_we <= 1'b0;
        end
    end

    // Sticky error flag; a set in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            monitor_error <= 1'b0;
        end else if (err_set) begin
            monitor_error <= 1'b1;
        end else if (err_clr) begin
            monitor_error <= 1'b0;
        end
    end

endmodule

// File: tb/tb_niosii_nios2_gen2_0_cpu_ocimem_seq.sv
// Directed bench for the ocimem sequencer with hand-computed expectations.
// Build with OCIMEM_TIMEOUT_EN defined to exercise the timeout path.
module tb_niosii_nios2_gen2_0_cpu_ocimem_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        ta_a;
    logic        ta_b;
    logic        tn_a;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        mem_err;
    logic [31:0] mem_rdata;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;

    int vectors = 0;
    int miscompares = 0;
    int low_cnt;

    always #5 clk = ~clk;

    niosii_nios2_gen2_0_cpu_ocimem_seq #(
        .AW      (8),
        .TIMEOUT (4)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (ta_a),
        .take_action_ocimem_b    (ta_b),
        .take_no_action_ocimem_a (tn_a),
        .mem_req                 (mem_req),
        .mem_we                  (mem_we),
        .mem_addr                (mem_addr),
        .mem_wdata               (mem_wdata),
        .mem_ack                 (mem_ack),
        .mem_err                 (mem_err),
        .mem_rdata               (mem_rdata),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic jdo_a(input logic [7:0] a, input logic rd,
                         input logic clr);
        jdo = '0;
        jdo[17:10] = a;
        jdo[35] = rd;
        jdo[36] = clr;
    endtask

    task automatic ack(input logic [31:0] d, input logic e);
        mem_ack = 1'b1;
        mem_err = e;
        mem_rdata = d;
        tick();
        mem_ack = 1'b0;
        mem_err = 1'b0;
        mem_rdata = '0;
    endtask

    initial begin
        reset = 1'b1;
        jdo = '0;
        ta_a = 0;
        ta_b = 0;
        tn_a = 0;
        mem_ack = 0;
        mem_err = 0;
        mem_rdata = '0;
        tick();
        tick();
        chk("rst_ready", 32'(monitor_ready), 0);
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_mon", MonDReg, 0);
        chk("rst_err", 32'(monitor_error), 0);
        reset = 1'b0;
        tick();
        chk("post_rst_ready", 32'(monitor_ready), 1);

        // Address load with read
        jdo_a(8'h12, 1'b1, 1'b0);
        ta_a = 1;
        tick();
        ta_a = 0;
        chk("ld_req", 32'(mem_req), 1);
        chk("ld_maddr", 32'(mem_addr), 32'h12);
        chk("ld_we", 32'(mem_we), 0);
        chk("ld_ready", 32'(monitor_ready), 0);
        tick();
        tick();
        chk("ld_req_hold", 32'(mem_req), 1);
        ack(32'hDEADBEEF, 1'b0);
        chk("ld_req_drop", 32'(mem_req), 0);
        chk("ld_mon", MonDReg, 32'hDEADBEEF);
        chk("ld_done_ready", 32'(monitor_ready), 0);
        tick();
        chk("ld_ready_back", 32'(monitor_ready), 1);
        tn_a = 1;
        tick();
        tn_a = 0;
        chk("ld_addr_kept", 32'(mem_addr), 32'h12);
        ack(32'h11223344, 1'b0);
        chk("na_mon", MonDReg, 32'h11223344);
        tick();

        // Write with wrap-around increment
        jdo_a(8'hFF, 1'b0, 1'b0);
        ta_a = 1;
        tick();
        ta_a = 0;
        chk("ld_noread_ready", 32'(monitor_ready), 1);
        chk("ld_noread_req", 32'(mem_req), 0);
        jdo = '0;
        jdo[34:3] = 32'hA5A5A5A5;
        ta_b = 1;
        tick();
        ta_b = 0;
        chk("wr_we", 32'(mem_we), 1);
        chk("wr_wdata", mem_wdata, 32'hA5A5A5A5);
        chk("wr_maddr", 32'(mem_addr), 32'hFF);
        ack(32'h0, 1'b0);
        chk("wr_mon_kept", MonDReg, 32'h11223344);
        tick();
        tn_a = 1;
        tick();
        tn_a = 0;
        chk("wr_wrap", 32'(mem_addr), 32'h00);
        ack(32'hCAFEF00D, 1'b0);
        tick();

        // Overrun during ACCESS
        tn_a = 1;
        tick();
        tn_a = 0;
        chk("ov_maddr", 32'(mem_addr), 32'h01);
        tn_a = 1;
        tick();
        tn_a = 0;
        chk("ov_err", 32'(monitor_error), 1);
        chk("ov_req", 32'(mem_req), 1);
        ack(32'h55AA55AA, 1'b0);
        tick();
        tick();
        chk("ov_single_req", 32'(mem_req), 0);
        chk("ov_ready", 32'(monitor_ready), 1);
        jdo_a(8'h40, 1'b0, 1'b1);
        ta_a = 1;
        tick();
        ta_a = 0;
        chk("ov_clear", 32'(monitor_error), 0);

        // Memory error on read
        tn_a = 1;
        tick();
        tn_a = 0;
        ack(32'h0BADBAD0, 1'b1);
        chk("me_mon", MonDReg, 32'h55AA55AA);
        chk("me_err", 32'(monitor_error), 1);
        tick();
        tn_a = 1;
        tick();
        tn_a = 0;
        chk("me_addr_kept", 32'(mem_addr), 32'h40);
        ack(32'h01020304, 1'b0);
        chk("me_sticky", 32'(monitor_error), 1);
        tick();
        jdo_a(8'h00, 1'b0, 1'b1);
        ta_a = 1;
        tick();
        ta_a = 0;

        // Timeout behaviour
        tn_a = 1;
        tick();
        tn_a = 0;
`ifdef OCIMEM_TIMEOUT_EN
        tick();
        tick();
        tick();
        chk("to_req_hold", 32'(mem_req), 1);
        tick();
        chk("to_req_drop", 32'(mem_req), 0);
        chk("to_err", 32'(monitor_error), 1);
        tick();
        tn_a = 1;
        tick();
        tn_a = 0;
`else
        low_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (!mem_req) low_cnt++;
        end
        chk("nto_req_low_cycles", low_cnt, 0);
        chk("nto_err", 32'(monitor_error), 0);
`endif

        // Reset in the middle of an access
        chk("rm_req", 32'(mem_req), 1);
        reset = 1'b1;
        tick();
        chk("rm_req_drop", 32'(mem_req), 0);
        chk("rm_ready_low", 32'(monitor_ready), 0);
        reset = 1'b0;
        ack(32'h99999999, 1'b0);
        chk("rm_late_ack", MonDReg, 0);
        chk("rm_ready", 32'(monitor_ready), 1);
        chk("rm_req_idle", 32'(mem_req), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/niosii_nios2_gen2_0_cpu_ocimem_seq.md
NIOSII_NIOS2_GEN2_0_CPU_OCIMEM_SEQ -- requirements
Module: niosii_nios2_gen2_0_cpu_ocimem_seq

Interface
REQ-001 SHALL have parameter AW, default 8: debug RAM word-address width.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum cycles to wait for mem_ack.
REQ-003 SHALL use one clock and a synchronous, active-high reset, as decided; the ports are named clk and reset.
REQ-004 clk  input  1  system clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 jdo  input  38  JTAG data word, already synchronised into the clk domain.
REQ-007 take_action_ocimem_a  input  1  one-cycle strobe: address-load command, with optional read.
REQ-008 take_action_ocimem_b  input  1  one-cycle strobe: write command.
REQ-009 take_no_action_ocimem_a  input  1  one-cycle strobe: read at the current address, then post-increment.
REQ-010 mem_req / mem_we  output  1 / 1  memory request and write enable.
REQ-011 mem_addr  output  AW  memory word address.
REQ-012 mem_wdata  output  32  memory write data.
REQ-013 mem_ack / mem_err  input  1 / 1  memory completion and error, valid only while mem_req is high.
REQ-014 mem_rdata  input  32  memory read data, valid with mem_ack.
REQ-015 MonDReg  output  32  last read data returned to the debug TCK side.
REQ-016 monitor_ready / monitor_error  output  1 / 1  sequencer idle; sticky error flag.

Function
REQ-017 SHALL decode jdo fields as follows: address jdo[AW+9:10]; write data jdo[34:3]; read-after-load jdo[35]; error-clear jdo[36].
REQ-018 SHALL implement the FSM states IDLE, ACCESS and DONE.
REQ-019 SHALL accept a strobe only in IDLE; the priority is ocimem_b, then ocimem_a, then no_action_a.
REQ-020 On ocimem_a, SHALL load addr and, if jdo[36]=1, clear monitor_error in the same cycle. If jdo[35]=1 it SHALL start a read without post-increment; otherwise it SHALL stay in IDLE.
REQ-021 On ocimem_b, SHALL latch the write data and start a write at addr, with post-increment.
REQ-022 On no_action_a, SHALL start a read at addr, with post-increment.
REQ-023 SHALL assert mem_req in the cycle after the accepted strobe (IDLE to ACCESS) and hold mem_req, mem_we, mem_addr and mem_wdata stable until completion.
REQ-024 On mem_ack with mem_err=0: a read SHALL load MonDReg from mem_rdata; addr SHALL increment if post-increment applies; the FSM SHALL go to DONE.
REQ-025 On mem_ack with mem_err=1: SHALL set monitor_error, leave MonDReg and addr unchanged, and go to DONE.
REQ-026 mem_req SHALL deassert in the cycle after mem_ack.
REQ-027 DONE SHALL return to IDLE after exactly one cycle.
REQ-028 monitor_ready SHALL be high only in IDLE.
REQ-029 Address increment SHALL wrap from 2^AW-1 to 0.
REQ-030 A strobe arriving outside IDLE SHALL be dropped and SHALL set monitor_error (overrun).
REQ-031 An error-clear and an error-set in the same cycle: set SHALL win.

Reset
REQ-032 While reset is high: FSM=IDLE; addr=0; MonDReg=0; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; monitor_error=0.
REQ-033 While reset is high, monitor_ready SHALL be 0; it SHALL be 1 from the first cycle after reset.
REQ-034 Reset during ACCESS SHALL drop mem_req in the next cycle with no write-back; a late mem_ack SHALL then be ignored.

Configuration
REQ-035 SHALL support the macro OCIMEM_TIMEOUT_EN; when it is defined, a cycle counter SHALL run while in ACCESS.
REQ-036 When the counter reaches TIMEOUT with no mem_ack, SHALL drop mem_req, set monitor_error and go to DONE; mem_ack in that same cycle SHALL win.
REQ-037 Without OCIMEM_TIMEOUT_EN, ACCESS SHALL wait for mem_ack indefinitely and no counter SHALL be instantiated.

Structure
REQ-038 Package niosii_ocimem_pkg SHALL hold the FSM state enum, the jdo field bit-position constants and the command-type enum (READ, READ_INC, WRITE_INC).
REQ-039 The timeout counter SHALL be the sub-module niosii_ocimem_timeout, instantiated only under OCIMEM_TIMEOUT_EN.

Verification
REQ-040 Address load then read: ocimem_a with jdo[17:10]=0x12 and jdo[35]=1, mem_ack with rdata 0xDEADBEEF after 3 cycles -> mem_addr=0x12; MonDReg=0xDEADBEEF; addr stays 0x12; monitor_ready high 2 cycles after ack.
REQ-041 Write with increment: addr=0xFF, ocimem_b with data 0xA5A5A5A5 -> mem_we=1, mem_wdata=0xA5A5A5A5, mem_addr=0xFF; after ack, addr=0x00.
REQ-042 Overrun: no_action_a pulsed during ACCESS -> monitor_error=1; only one mem_req transaction occurs; error cleared by ocimem_a with jdo[36]=1.
REQ-043 Memory error: mem_ack with mem_err=1 on a read -> MonDReg unchanged; addr unchanged; monitor_error=1.
REQ-044 Timeout (macro defined, TIMEOUT=4): no mem_ack -> mem_req drops after 4 cycles and monitor_error=1; same test without the macro -> mem_req stays high for 1000 cycles.
REQ-045 Reset mid-access: reset during ACCESS -> mem_req=0 next cycle; a later mem_ack leaves MonDReg=0.
